// File: rtl/uart_pkg.sv
// Constants shared by the UART Tx parity generator and the Rx parity checker:
// parity-type encodings, the Rx parity FSM state encoding and the default frame width.
package uart_pkg;

    localparam logic EVEN_PARITY        = 1'b0;
    localparam logic ODD_PARITY         = 1'b1;
    localparam int   DEFAULT_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } rx_par_state_e;

endpackage : uart_pkg

// File: rtl/uart_rx_parity_check.sv
// Rx parity checker: deserialises the data bits of a UART frame and checks the received parity bit.
// Optional build macro UART_RX_PAR_ERR_CNT_EN adds a saturating 8-bit parity-error counter output.
module uart_rx_parity_check
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_start,
    input  logic                  bit_valid,
    input  logic                  sampled_bit,
    input  logic                  par_en,
    input  logic                  par_type,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  par_done,
    output logic                  par_err,
    output logic                  busy
`ifdef UART_RX_PAR_ERR_CNT_EN
    ,
    output logic [7:0]            par_err_cnt
`endif
);

    localparam int CNT_W = $clog2(DATA_WIDTH);

    rx_par_state_e         state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic                  accum_q, accum_d;
    logic                  par_en_q, par_en_d;
    logic                  par_type_q, par_type_d;
    logic                  par_done_q, par_done_d;
    logic                  par_err_q, par_err_d;

    // NOTE: every signal gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        data_out_d = data_out_q;
        bit_cnt_d  = bit_cnt_q;
        accum_d    = accum_q;
        par_en_d   = par_en_q;
        par_type_d = par_type_q;
        par_done_d = 1'b0;
        par_err_d  = par_err_q;

        // frame_start takes priority in every state: it aborts any frame in flight.
        if (frame_start) begin
            state_d    = DATA;
            shift_d    = '0;
            bit_cnt_d  = '0;
            accum_d    = 1'b0;
            par_en_d   = par_en;
            par_type_d = par_type;
        end else begin
            unique case (state_q)
                DATA: begin
                    if (bit_valid) begin
                        shift_d   = {sampled_bit, shift_q[DATA_WIDTH-1:1]};
                        accum_d   = accum_q ^ sampled_bit;
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                            if (par_en_q) begin
                                state_d = PARITY;
                            end else begin
                                state_d    = IDLE;
                                par_done_d = 1'b1;
                                par_err_d  = 1'b0;
                                data_out_d = shift_d;
                            end
                        end
                    end
                end
                PARITY: begin
                    if (bit_valid) begin
                        par_err_d  = (sampled_bit != (accum_q ^ par_type_q));
                        data_out_d = shift_q;
                        par_done_d = 1'b1;
                        state_d    = IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            data_out_q <= '0;
            bit_cnt_q  <= '0;
            accum_q    <= 1'b0;
            par_en_q   <= 1'b0;
            par_type_q <= EVEN_PARITY;
            par_done_q <= 1'b0;
            par_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            data_out_q <= data_out_d;
            bit_cnt_q  <= bit_cnt_d;
            accum_q    <= accum_d;
            par_en_q   <= par_en_d;
            par_type_q <= par_type_d;
            par_done_q <= par_done_d;
            par_err_q  <= par_err_d;
        end
    end

    assign data_out = data_out_q;
    assign par_done = par_done_q;
    assign par_err  = par_err_q;
    assign busy     = (state_q == DATA) || (state_q == PARITY);

`ifdef UART_RX_PAR_ERR_CNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    // Saturating count of completed frames whose parity mismatched.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (par_done_d && par_err_d && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign par_err_cnt = err_cnt_q;
`endif

endmodule : uart_rx_parity_check
